// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe delay line: parameter defaults,
// clock-edge encoding and the occupancy counter width helper.
package dff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Edge-select encoding for the NEG_EDGE parameter
    localparam bit EDGE_POS = 1'b0;
    localparam bit EDGE_NEG = 1'b1;

    // Bits needed to hold an occupancy value 0..depth, never less than one
    function automatic int cnt_w(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/control bundle between a producer and the dff_pipe delay line.
// The master drives the word and its controls; the slave (the pipe)
// returns the delayed word, its complement, valid flag and occupancy.
interface dff_pipe_if import dff_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    logic                      en;
    logic                      flush;
    logic [WIDTH-1:0]          d;
    logic                      d_valid;
    logic [WIDTH-1:0]          q;
    logic [WIDTH-1:0]          qn;
    logic                      q_valid;
    logic [cnt_w(DEPTH)-1:0]   count;

    modport master (
        output en, flush, d, d_valid,
        input  q, qn, q_valid, count
    );

    modport slave (
        input  en, flush, d, d_valid,
        output q, qn, q_valid, count
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Data follows en only; flush clears the valid bit but leaves data alone,
// since the contents of an invalid stage are never looked at.
module dff_stage import dff_pkg::*; #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter bit               NEG_EDGE  = EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    generate
        if (NEG_EDGE == EDGE_NEG) begin : g_neg
            // Falling-edge stage register with immediate reset
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_out <= RESET_VAL;
                    v_out <= 1'b0;
                end else begin
                    if (en)
                        d_out <= d_in;
                    if (flush)
                        v_out <= 1'b0;
                    else if (en)
                        v_out <= v_in;
                end
            end
        end else begin : g_pos
            // Rising-edge stage register with immediate reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_out <= RESET_VAL;
                    v_out <= 1'b0;
                end else begin
                    if (en)
                        d_out <= d_in;
                    if (flush)
                        v_out <= 1'b0;
                    else if (en)
                        v_out <= v_in;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dff_pipe.sv
// Stallable, flushable fixed-latency delay line of DEPTH stages.
// Words advance one stage per enabled active edge; the last stage drives
// q/q_valid directly, qn is its combinational complement and count tracks
// how many stages currently hold valid data.
module dff_pipe import dff_pkg::*; #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter bit               NEG_EDGE  = EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic       clk,
    input logic       rst_n,
    dff_pipe_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             stage_v [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             last_v;

    assign last_v = stage_v[DEPTH-1];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] src_d;
            logic             src_v;
            if (i == 0) begin : g_head
                assign src_d = bus.d;
                assign src_v = bus.d_valid;
            end else begin : g_body
                assign src_d = stage_d[i-1];
                assign src_v = stage_v[i-1];
            end
            dff_stage #(
                .WIDTH     (WIDTH),
                .NEG_EDGE  (NEG_EDGE),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (bus.en),
                .flush (bus.flush),
                .d_in  (src_d),
                .v_in  (src_v),
                .d_out (stage_d[i]),
                .v_out (stage_v[i])
            );
        end
    endgenerate

    // Occupancy rises when a valid word enters and falls when one leaves
    always_comb begin
        count_nxt = count_q;
        if (bus.flush)
            count_nxt = '0;
        else if (bus.en) begin
            if (bus.d_valid && !last_v)
                count_nxt = count_q + CNT_ONE;
            else if (!bus.d_valid && last_v)
                count_nxt = count_q - CNT_ONE;
        end
    end

    generate
        if (NEG_EDGE == EDGE_NEG) begin : g_cnt_neg
            // Occupancy register clocked on the same falling edge as the stages
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n)
                    count_q <= '0;
                else
                    count_q <= count_nxt;
            end
        end else begin : g_cnt_pos
            // Occupancy register clocked on the same rising edge as the stages
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    count_q <= '0;
                else
                    count_q <= count_nxt;
            end
        end
    endgenerate

    assign bus.q       = stage_d[DEPTH-1];
    assign bus.qn      = ~stage_d[DEPTH-1];
    assign bus.q_valid = last_v;
    assign bus.count   = count_q;

    // Occupancy can never exceed the number of stages
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (int'(count_q) <= DEPTH);
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a falling-edge 8x4 pipe exercises latency,
// streaming, stall, flush and async reset; a rising-edge 1x1 pipe checks
// single-stage behaviour.
module tb_dff_pipe;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
    dff_pipe_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

    dff_pipe #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b1), .RESET_VAL(8'h00)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1), .NEG_EDGE(1'b0), .RESET_VAL(1'b0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        bus0.en = 1'b0; bus0.flush = 1'b0; bus0.d = 8'h00; bus0.d_valid = 1'b0;
        bus1.en = 1'b0; bus1.flush = 1'b0; bus1.d = 1'b0;  bus1.d_valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        tests_run += 6;
        if (bus0.q !== 8'h00)     begin tests_failed++; $display("[TB] FAIL reset_q: got %h expected 00", bus0.q); end
        if (bus0.qn !== 8'hFF)    begin tests_failed++; $display("[TB] FAIL reset_qn: got %h expected ff", bus0.qn); end
        if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_qv: got %b expected 0", bus0.q_valid); end
        if (bus0.count !== 3'd0)  begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", bus0.count); end
        if (bus1.q !== 1'b0)      begin tests_failed++; $display("[TB] FAIL reset_q1: got %b expected 0", bus1.q); end
        if (bus1.qn !== 1'b1)     begin tests_failed++; $display("[TB] FAIL reset_qn1: got %b expected 1", bus1.qn); end
        step();
        tests_run++;
        if (bus0.count !== 3'd0)  begin tests_failed++; $display("[TB] FAIL reset_hold_count: got %0d expected 0", bus0.count); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        bus0.en = 1'b1; bus0.flush = 1'b0;
        bus0.d = 8'hA5; bus0.d_valid = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            bus0.d = 8'h00; bus0.d_valid = 1'b0;
            tests_run += 2;
            if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_qv_e%0d: got %b expected 0", e, bus0.q_valid); end
            if (bus0.count !== 3'd1)   begin tests_failed++; $display("[TB] FAIL single_count_e%0d: got %0d expected 1", e, bus0.count); end
        end
        step();
        chk8("single_q_e4", bus0.q, 8'hA5);
        chk8("single_qn_e4", bus0.qn, 8'h5A);
        tests_run += 2;
        if (bus0.q_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_qv_e4: got %b expected 1", bus0.q_valid); end
        if (bus0.count !== 3'd1)   begin tests_failed++; $display("[TB] FAIL single_count_e4: got %0d expected 1", bus0.count); end
        @(posedge clk);
        #1;
        chk8("single_q_rise", bus0.q, 8'hA5);
        tests_run++;
        if (bus0.q_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_qv_rise: got %b expected 1", bus0.q_valid); end
        step();
        tests_run += 2;
        if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_qv_e5: got %b expected 0", bus0.q_valid); end
        if (bus0.count !== 3'd0)   begin tests_failed++; $display("[TB] FAIL single_count_e5: got %0d expected 0", bus0.count); end
    endtask

    task automatic test_stream();
        int exp_cnt [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
        bus0.en = 1'b1; bus0.flush = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            bus0.d       = (e <= 5) ? 8'(e) : 8'h00;
            bus0.d_valid = (e <= 5);
            step();
            tests_run += 2;
            if (bus0.count !== 3'(exp_cnt[e-1])) begin
                tests_failed++;
                $display("[TB] FAIL stream_count_e%0d: got %0d expected %0d", e, bus0.count, exp_cnt[e-1]);
            end
            if (bus0.q_valid !== (e >= 4 && e <= 8)) begin
                tests_failed++;
                $display("[TB] FAIL stream_qv_e%0d: got %b expected %b", e, bus0.q_valid, (e >= 4 && e <= 8));
            end
            if (e >= 4 && e <= 8)
                chk8($sformatf("stream_q_e%0d", e), bus0.q, 8'(e - 3));
        end
        bus0.d_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        int         exp_cnt [4] = '{3, 2, 1, 0};
        bus0.en = 1'b1; bus0.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.d = words[i]; bus0.d_valid = 1'b1;
            step();
        end
        bus0.en = 1'b0; bus0.d = 8'hEE; bus0.d_valid = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            step();
            chk8($sformatf("stall_q_s%0d", s), bus0.q, 8'h00);
            tests_run += 2;
            if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_qv_s%0d: got %b expected 0", s, bus0.q_valid); end
            if (bus0.count !== 3'd3)   begin tests_failed++; $display("[TB] FAIL stall_count_s%0d: got %0d expected 3", s, bus0.count); end
        end
        bus0.en = 1'b1; bus0.d = 8'h00; bus0.d_valid = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            step();
            tests_run += 2;
            if (bus0.q_valid !== (r <= 3)) begin tests_failed++; $display("[TB] FAIL resume_qv_r%0d: got %b expected %b", r, bus0.q_valid, (r <= 3)); end
            if (bus0.count !== 3'(exp_cnt[r-1])) begin tests_failed++; $display("[TB] FAIL resume_count_r%0d: got %0d expected %0d", r, bus0.count, exp_cnt[r-1]); end
            if (r <= 3)
                chk8($sformatf("resume_q_r%0d", r), bus0.q, words[r-1]);
        end
    endtask

    task automatic test_flush();
        bus0.en = 1'b1; bus0.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.d = 8'h61 + 8'(i); bus0.d_valid = 1'b1;
            step();
        end
        tests_run++;
        if (bus0.count !== 3'd3) begin tests_failed++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", bus0.count); end
        bus0.flush = 1'b1; bus0.d = 8'h77; bus0.d_valid = 1'b1;
        step();
        bus0.flush = 1'b0; bus0.d = 8'h00; bus0.d_valid = 1'b0;
        tests_run += 2;
        if (bus0.count !== 3'd0)   begin tests_failed++; $display("[TB] FAIL flush_count: got %0d expected 0", bus0.count); end
        if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_qv: got %b expected 0", bus0.q_valid); end
        for (int e = 1; e <= 4; e++) begin
            step();
            tests_run += 2;
            if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_drain_qv_e%0d: got %b expected 0", e, bus0.q_valid); end
            if (bus0.count !== 3'd0)   begin tests_failed++; $display("[TB] FAIL flush_drain_count_e%0d: got %0d expected 0", e, bus0.count); end
        end
    endtask

    task automatic test_async_reset();
        bus0.en = 1'b1; bus0.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus0.d = 8'h81 + 8'(i); bus0.d_valid = 1'b1;
            step();
        end
        chk8("areset_pre_q", bus0.q, 8'h81);
        #2 rst_n = 1'b0;
        #1;
        chk8("areset_q", bus0.q, 8'h00);
        chk8("areset_qn", bus0.qn, 8'hFF);
        tests_run += 2;
        if (bus0.q_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_qv: got %b expected 0", bus0.q_valid); end
        if (bus0.count !== 3'd0)   begin tests_failed++; $display("[TB] FAIL areset_count: got %0d expected 0", bus0.count); end
        #3 rst_n = 1'b1;
        bus0.d = 8'h9A; bus0.d_valid = 1'b1;
        step();
        bus0.d = 8'h00; bus0.d_valid = 1'b0;
        tests_run++;
        if (bus0.count !== 3'd1) begin tests_failed++; $display("[TB] FAIL areset_resume_count: got %0d expected 1", bus0.count); end
        for (int e = 2; e <= 4; e++)
            step();
        chk8("areset_resume_q", bus0.q, 8'h9A);
        tests_run++;
        if (bus0.q_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_resume_qv: got %b expected 1", bus0.q_valid); end
        bus0.en = 1'b0;
    endtask

    task automatic test_rising_single();
        logic [9:0] pat = 10'b1011001110;
        bus1.en = 1'b1; bus1.flush = 1'b0; bus1.d_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus1.d = pat[i];
            @(posedge clk);
            #1;
            tests_run += 3;
            if (bus1.q !== pat[i])   begin tests_failed++; $display("[TB] FAIL rise_q_c%0d: got %b expected %b", i, bus1.q, pat[i]); end
            if (bus1.qn !== ~pat[i]) begin tests_failed++; $display("[TB] FAIL rise_qn_c%0d: got %b expected %b", i, bus1.qn, ~pat[i]); end
            if (bus1.count !== 1'b1) begin tests_failed++; $display("[TB] FAIL rise_count_c%0d: got %0d expected 1", i, bus1.count); end
            @(negedge clk);
            #1;
            tests_run++;
            if (bus1.q !== pat[i])   begin tests_failed++; $display("[TB] FAIL rise_hold_c%0d: got %b expected %b", i, bus1.q, pat[i]); end
        end
        bus1.d_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus1.count !== 1'b0) begin tests_failed++; $display("[TB] FAIL rise_drain_count: got %0d expected 0", bus1.count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_word();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_rising_single();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
